// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sram_responder
//  Purpose  : MEM-stage responder that splits each 32-bit read/write request
//             into two 16-bit accesses to an external asynchronous SRAM and
//             holds ready low while the transaction is in flight.
//  Options  : SRAM_LAST_READ_BYPASS_EN - repeat reads of the last-read word
//             complete in the request cycle without touching the SRAM.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_responder #(
    parameter int ADDR_BASE     = 1024,
    parameter int SRAM_ADDR_W   = 18,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            address,
    input  logic [31:0]            data,
    output logic [31:0]            mem_result,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n
);

    localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int IDX_W = SRAM_ADDR_W - 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // Transaction latched on the IDLE->LOW edge
    logic             r_is_write;
    logic [IDX_W-1:0] r_index;
    logic [31:0]      r_data;

    logic             w_req;
    logic             w_hit;
    logic [31:0]      w_offset;
    logic [IDX_W-1:0] w_req_index;
    logic             w_unused_offset_bits;

    // What the transaction looks like in the coming cycle (IDLE uses live inputs)
    logic             w_is_write_n;
    logic [IDX_W-1:0] w_index_n;
    logic [31:0]      w_data_n;
    logic             w_phase_n;
    logic             w_high_n;

    assign w_req       = mem_read | mem_write;
    assign w_offset    = address - 32'(ADDR_BASE);
    assign w_req_index = w_offset[SRAM_ADDR_W:2];
    // Byte-lane bits and index bits beyond the SRAM are intentionally dropped
    assign w_unused_offset_bits = ^{w_offset[31:SRAM_ADDR_W+1], w_offset[1:0]};

`ifdef SRAM_LAST_READ_BYPASS_EN
    logic [IDX_W-1:0] r_tag_index;
    logic             r_tag_valid;

    // Pure read of the word already held in mem_result
    assign w_hit = (r_state == S_IDLE) && mem_read && !mem_write &&
                   r_tag_valid && (w_req_index == r_tag_index);

    // Track which word mem_result holds; a write to it invalidates the copy
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tag_valid <= 1'b0;
            r_tag_index <= '0;
        end else if (r_state == S_DONE) begin
            if (!r_is_write) begin
                r_tag_index <= r_index;
                r_tag_valid <= 1'b1;
            end else if (r_index == r_tag_index) begin
                r_tag_valid <= 1'b0;
            end
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    assign ready = !(w_req && (r_state != S_DONE) && !w_hit);

    assign w_is_write_n = (r_state == S_IDLE) ? mem_write   : r_is_write;
    assign w_index_n    = (r_state == S_IDLE) ? w_req_index : r_index;
    assign w_data_n     = (r_state == S_IDLE) ? data        : r_data;
    assign w_phase_n    = (w_state_next == S_LOW) || (w_state_next == S_HIGH);
    assign w_high_n     = (w_state_next == S_HIGH);

    // State and phase counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and phase counter sequencing
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    w_state_next = S_LOW;
                    w_cnt_next   = '0;
                end
            end
            S_LOW: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_next = S_DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Capture the request when leaving IDLE; later input changes are ignored
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_is_write <= 1'b0;
            r_index    <= '0;
            r_data     <= '0;
        end else if (r_state == S_IDLE && w_state_next == S_LOW) begin
            r_is_write <= mem_write;
            r_index    <= w_req_index;
            r_data     <= data;
        end
    end

    // Registered SRAM pins, computed from the state being entered
    always_ff @(posedge clk) begin
        if (!rst) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_ce_n   <= 1'b1;
        end else begin
            sram_ce_n  <= !w_phase_n;
            sram_oe_n  <= !(w_phase_n && !w_is_write_n);
            sram_dq_oe <= w_phase_n && w_is_write_n;
            // Strobe released in the last phase cycle so address/data hold past WE rise
            sram_we_n  <= !(w_phase_n && w_is_write_n && (w_cnt_next != c_cnt_last));
            if (w_phase_n) begin
                sram_addr <= {w_index_n, w_high_n};
                if (w_is_write_n) begin
                    sram_dq_out <= w_high_n ? w_data_n[31:16] : w_data_n[15:0];
                end
            end
        end
    end

    // Read data capture at the end of each halfword phase
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_result <= '0;
        end else if (!r_is_write && r_cnt == c_cnt_last) begin
            if (r_state == S_LOW) begin
                mem_result[15:0] <= sram_dq_in;
            end else if (r_state == S_HIGH) begin
                mem_result[31:16] <= sram_dq_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_responder
//  Purpose  : Directed self-checking bench for sram_responder with a simple
//             behavioural halfword SRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_responder;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] data;
    logic [31:0] mem_result;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;

    int n_tests;
    int n_fail;
    int we_cnt;
    int oe_cnt;
    int dqoe_cnt;
    int lat;

`ifdef SRAM_LAST_READ_BYPASS_EN
    localparam int c_repeat_lat = 0;
`else
    localparam int c_repeat_lat = 5;
`endif

    logic [15:0] sram_mem [0:255];

    sram_responder dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .address     (address),
        .data        (data),
        .mem_result  (mem_result),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n),
        .sram_ce_n   (sram_ce_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: combinational read, write while strobe is low
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end

    // Strobe activity counters, sampled mid-cycle
    always @(negedge clk) begin
        if (!sram_we_n)  we_cnt++;
        if (!sram_oe_n)  oe_cnt++;
        if (sram_dq_oe)  dqoe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue a request at a falling edge and count cycles with ready low
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int cycles);
        we_cnt    = 0;
        oe_cnt    = 0;
        dqoe_cnt  = 0;
        mem_read  = rd;
        mem_write = wr;
        address   = a;
        data      = d;
        cycles    = 0;
        #1;
        while (!ready && cycles < 20) begin
            cycles++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic end_req();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        we_cnt    = 0;
        oe_cnt    = 0;
        dqoe_cnt  = 0;
        rst       = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        address   = 32'd0;
        data      = 32'd0;
        repeat (3) @(negedge clk);

        check("reset_ready",      {31'd0, ready},      32'd1);
        check("reset_mem_result", mem_result,          32'd0);
        check("reset_addr",       {14'd0, sram_addr},  32'd0);
        check("reset_ce_n",       {31'd0, sram_ce_n},  32'd1);
        check("reset_we_n",       {31'd0, sram_we_n},  32'd1);
        check("reset_oe_n",       {31'd0, sram_oe_n},  32'd1);
        check("reset_dq_oe",      {31'd0, sram_dq_oe}, 32'd0);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", {31'd0, ready},     32'd1);
        check("idle_ce_n",  {31'd0, sram_ce_n}, 32'd1);

        // Write 0xDEADBEEF to word 0
        run_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat);
        check("wr0_latency", lat,            32'd5);
        check("wr0_we_cnt",  we_cnt,         32'd2);
        check("wr0_result",  mem_result,     32'd0);
        end_req();
        check("wr0_hw0", {16'd0, sram_mem[0]}, 32'h0000BEEF);
        check("wr0_hw1", {16'd0, sram_mem[1]}, 32'h0000DEAD);

        // Read it back
        run_req(1'b1, 1'b0, 32'd1024, 32'd0, lat);
        check("rd0_latency", lat,        32'd5);
        check("rd0_result",  mem_result, 32'hDEADBEEF);
        check("rd0_dqoe",    dqoe_cnt,   32'd0);
        check("rd0_oe_cnt",  oe_cnt,     32'd4);
        end_req();

        // Read and write together is a write
        run_req(1'b1, 1'b1, 32'd1028, 32'h12345678, lat);
        check("both_latency", lat,        32'd5);
        check("both_result",  mem_result, 32'hDEADBEEF);
        end_req();
        check("both_hw2", {16'd0, sram_mem[2]}, 32'h00005678);
        check("both_hw3", {16'd0, sram_mem[3]}, 32'h00001234);

        run_req(1'b1, 1'b0, 32'd1028, 32'd0, lat);
        check("rd1_latency", lat,        32'd5);
        check("rd1_result",  mem_result, 32'h12345678);
        end_req();

        // Reset during the HIGH phase of a read
        mem_read = 1'b1;
        address  = 32'd1024;
        repeat (3) @(negedge clk);
        check("abort_busy", {31'd0, ready}, 32'd0);
        rst      = 1'b0;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        check("abort_oe_n",   {31'd0, sram_oe_n},  32'd1);
        check("abort_ce_n",   {31'd0, sram_ce_n},  32'd1);
        check("abort_result", mem_result,          32'd0);
        check("abort_ready",  {31'd0, ready},      32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Index wraps modulo the SRAM size
        run_req(1'b0, 1'b1, 32'd1024 + 32'd524288, 32'hCAFEF00D, lat);
        check("wrap_latency", lat, 32'd5);
        end_req();
        check("wrap_hw0", {16'd0, sram_mem[0]}, 32'h0000F00D);
        check("wrap_hw1", {16'd0, sram_mem[1]}, 32'h0000CAFE);

        run_req(1'b1, 1'b0, 32'd1024, 32'd0, lat);
        check("rd2_latency", lat,        32'd5);
        check("rd2_result",  mem_result, 32'hCAFEF00D);
        end_req();

        // Repeat read of the same word
        run_req(1'b1, 1'b0, 32'd1024, 32'd0, lat);
        check("rep_latency", lat,        c_repeat_lat);
        check("rep_result",  mem_result, 32'hCAFEF00D);
        end_req();

        // Write to that word then read: always a full access
        run_req(1'b0, 1'b1, 32'd1024, 32'h11112222, lat);
        check("wr3_latency", lat, 32'd5);
        end_req();
        run_req(1'b1, 1'b0, 32'd1024, 32'd0, lat);
        check("rd3_latency", lat,        32'd5);
        check("rd3_result",  mem_result, 32'h11112222);
        end_req();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
